// File: rtl/syn_pcm_buf_pkg.sv
// Shared types and helpers for the PCM ping-pong buffer responder.
package syn_pcm_buf_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } wr_state_e;

  localparam int unsigned PCM_HALF_W = 16;

  typedef struct packed {
    logic [PCM_HALF_W-1:0] left;
    logic [PCM_HALF_W-1:0] right;
  } pcm_word_t;

  function automatic int unsigned bank_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/syn_pcm_buf_bank_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered,
// enable-gated output that holds between reads.
module syn_pcm_bank_ram
  import syn_pcm_buf_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [bank_depth(ADDR_W)];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/syn_pcm_buf_rsp.sv
// PCM read responder: ping-pong sample capture, bank release handshake and
// fixed-latency read pipe.
module syn_pcm_buf_rsp
  import syn_pcm_buf_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RD_DELAY = 2,
  parameter int unsigned OVF_W    = 16
) (
  input  logic              clk_ir,
  input  logic              rst_ih,
  input  logic              smpl_valid_i,
  input  logic [DATA_W-1:0] smpl_data_i,
  output logic              pcm_data_rdy,
  input  logic [ADDR_W-1:0] pcm_addr,
  input  logic              pcm_rden,
  output logic [DATA_W-1:0] pcm_rdata,
  output logic              pcm_rd_valid,
  output logic [OVF_W-1:0]  ovf_cnt_o
);

  localparam int unsigned       DEPTH     = bank_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  wr_state_e         state, state_nxt;
  logic              wbank, wbank_nxt;
  logic [ADDR_W-1:0] wptr, wptr_nxt;
  logic              rdy, rdy_nxt;
  logic [OVF_W-1:0]  ovf_cnt;
  logic              wr_en, wr_bank, ovf_inc, rd_release;
  logic [DATA_W-1:0] ram_q;
  logic [RD_DELAY-1:0] vld;

  assign rd_release = pcm_rden && (pcm_addr == LAST_ADDR) && rdy;

  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      state   <= FILL;
      wbank   <= 1'b0;
      wptr    <= '0;
      rdy     <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      state <= state_nxt;
      wbank <= wbank_nxt;
      wptr  <= wptr_nxt;
      rdy   <= rdy_nxt;
      if (ovf_inc && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + OVF_W'(1);
    end
  end

  // A swap always sets rdy, so a release coinciding with a swap keeps it high.
  always_comb begin
    state_nxt = state;
    wbank_nxt = wbank;
    wptr_nxt  = wptr;
    rdy_nxt   = rdy && !rd_release;
    wr_en     = 1'b0;
    wr_bank   = wbank;
    ovf_inc   = 1'b0;
    case (state)
      FILL: begin
        if (smpl_valid_i) begin
          wr_en    = 1'b1;
          wptr_nxt = wptr + ADDR_W'(1);
          if (wptr == LAST_ADDR) begin
            if (!rdy || rd_release) begin
              wbank_nxt = ~wbank;
              rdy_nxt   = 1'b1;
            end else begin
              state_nxt = FULL;
            end
          end
        end
      end
      FULL: begin
        if (rd_release) begin
          wbank_nxt = ~wbank;
          rdy_nxt   = 1'b1;
          state_nxt = FILL;
          wr_bank   = ~wbank;
          if (smpl_valid_i) begin
            wr_en    = 1'b1;
            wptr_nxt = wptr + ADDR_W'(1);
          end
        end else if (smpl_valid_i) begin
          ovf_inc = 1'b1;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  syn_pcm_bank_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W + 1)
  ) u_ram (
    .clk   (clk_ir),
    .rst   (rst_ih),
    .we    (wr_en),
    .waddr ({wr_bank, wptr}),
    .wdata (smpl_data_i),
    .re    (pcm_rden),
    .raddr ({~wbank, pcm_addr}),
    .rdata (ram_q)
  );

  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      vld <= '0;
    end else begin
      vld[0] <= pcm_rden;
      for (int unsigned i = 1; i < RD_DELAY; i++) vld[i] <= vld[i-1];
    end
  end

  generate
    if (RD_DELAY > 1) begin : g_dly
      logic [DATA_W-1:0] stg [RD_DELAY-1];
      always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
          for (int unsigned i = 0; i < RD_DELAY - 1; i++) stg[i] <= '0;
        end else begin
          if (vld[0]) stg[0] <= ram_q;
          for (int unsigned i = 1; i < RD_DELAY - 1; i++)
            if (vld[i]) stg[i] <= stg[i-1];
        end
      end
      assign pcm_rdata = stg[RD_DELAY-2];
    end else begin : g_nodly
      assign pcm_rdata = ram_q;
    end
  endgenerate

  assign pcm_rd_valid = vld[RD_DELAY-1];
  assign pcm_data_rdy = rdy;
  assign ovf_cnt_o    = ovf_cnt;

endmodule

// File: tb/tb_syn_pcm_buf_rsp.sv
// Scoreboard bench for syn_pcm_buf_rsp: reads push expected data/due cycle,
// a negedge monitor pops and compares.
module tb_syn_pcm_buf_rsp;

  localparam int unsigned RD = 2;
  localparam logic [31:0] X_SMPL = 32'hCAFE0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        smpl_valid = 1'b0;
  logic [31:0] smpl_data = '0;
  logic        pcm_data_rdy;
  logic [7:0]  pcm_addr = '0;
  logic        pcm_rden = 1'b0;
  logic [31:0] pcm_rdata;
  logic        pcm_rd_valid;
  logic [15:0] ovf_cnt;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  syn_pcm_buf_rsp #(
    .DATA_W   (32),
    .ADDR_W   (8),
    .RD_DELAY (RD),
    .OVF_W    (16)
  ) dut (
    .clk_ir       (clk),
    .rst_ih       (rst),
    .smpl_valid_i (smpl_valid),
    .smpl_data_i  (smpl_data),
    .pcm_data_rdy (pcm_data_rdy),
    .pcm_addr     (pcm_addr),
    .pcm_rden     (pcm_rden),
    .pcm_rdata    (pcm_rdata),
    .pcm_rd_valid (pcm_rd_valid),
    .ovf_cnt_o    (ovf_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].due == cyc) begin
      chk("rd_valid", 32'(pcm_rd_valid), 32'd1);
      chk("rd_data", pcm_rdata, sb[0].data);
      void'(sb.pop_front());
    end else if (pcm_rd_valid) begin
      chk("rd_valid_unexp", 32'(pcm_rd_valid), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_rd(input logic [7:0] a, input logic [31:0] e);
    pcm_rden = 1'b1;
    pcm_addr = a;
    sb.push_back('{e, cyc + RD});
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      smpl_valid = 1'b1;
      smpl_data  = base + 32'(i);
      step();
    end
    smpl_valid = 1'b0;
  endtask

  task automatic read_seq(input int lo, input int hi, input logic [31:0] base);
    for (int a = lo; a <= hi; a++) begin
      issue_rd(8'(a), base + 32'(a));
      step();
    end
    pcm_rden = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_rdy(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (pcm_data_rdy) break;
      step();
    end
    chk("wait_rdy", 32'(pcm_data_rdy), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    rst = 1'b0;
    chk("rst_rdy", 32'(pcm_data_rdy), 32'd0);
    chk("rst_valid", 32'(pcm_rd_valid), 32'd0);
    chk("rst_rdata", pcm_rdata, 32'd0);
    chk("rst_ovf", 32'(ovf_cnt), 32'd0);

    // Fill one bank, read it back
    for (int i = 0; i < 256; i++) begin
      smpl_valid = 1'b1;
      smpl_data  = 32'(i);
      if (i == 255) chk("fill_rdy_early", 32'(pcm_data_rdy), 32'd0);
      step();
    end
    smpl_valid = 1'b0;
    chk("fill_rdy", 32'(pcm_data_rdy), 32'd1);
    read_seq(0, 255, 32'd0);
    chk("rel_rdy", 32'(pcm_data_rdy), 32'd0);
    drain();
    chk("rdata_hold", pcm_rdata, 32'd255);

    // Ping-pong with concurrent drain
    fork
      begin
        for (int i = 0; i < 512; i++) begin
          smpl_valid = 1'b1;
          smpl_data  = 32'(i);
          step();
        end
        smpl_valid = 1'b0;
      end
      begin
        for (int n = 0; n < 600; n++) begin
          if (pcm_data_rdy) break;
          step();
        end
        chk("pp_rdy0", 32'(pcm_data_rdy), 32'd1);
        read_seq(0, 255, 32'd0);
      end
    join
    wait_rdy(10);
    chk("pp_ovf", 32'(ovf_cnt), 32'd0);
    read_seq(0, 255, 32'd256);
    drain();

    // Overflow, then release in FULL with a same-cycle sample
    fill(32'd1000, 512);
    fill(32'hDEAD0000, 5);
    chk("ovf5", 32'(ovf_cnt), 32'd5);
    chk("ovf_rdy", 32'(pcm_data_rdy), 32'd1);
    issue_rd(8'd255, 32'd1255);
    smpl_valid = 1'b1;
    smpl_data  = X_SMPL;
    step();
    pcm_rden   = 1'b0;
    smpl_valid = 1'b0;
    chk("ovf_swap_rdy", 32'(pcm_data_rdy), 32'd1);
    chk("ovf_kept", 32'(ovf_cnt), 32'd5);
    for (int i = 1; i < 256; i++) begin
      smpl_valid = 1'b1;
      smpl_data  = 32'd2000 + 32'(i);
      step();
    end
    smpl_valid = 1'b0;
    read_seq(0, 255, 32'd1256);
    chk("ovf_rdy2", 32'(pcm_data_rdy), 32'd1);
    issue_rd(8'd0, X_SMPL);
    step();
    issue_rd(8'd1, 32'd2001);
    step();
    issue_rd(8'd255, 32'd2255);
    step();
    pcm_rden = 1'b0;
    chk("ovf_rel_rdy", 32'(pcm_data_rdy), 32'd0);
    drain();

    // Release and completion in the same cycle
    fill(32'd3000, 256);
    chk("sc_rdy", 32'(pcm_data_rdy), 32'd1);
    read_seq(0, 254, 32'd3000);
    fill(32'd4000, 255);
    issue_rd(8'd255, 32'd3255);
    smpl_valid = 1'b1;
    smpl_data  = 32'd4255;
    step();
    pcm_rden   = 1'b0;
    smpl_valid = 1'b0;
    chk("sc_rdy_hold", 32'(pcm_data_rdy), 32'd1);
    step();
    step();
    chk("sc_rdy_hold2", 32'(pcm_data_rdy), 32'd1);
    chk("sc_ovf", 32'(ovf_cnt), 32'd5);
    issue_rd(8'd0, 32'd4000);
    step();
    issue_rd(8'd255, 32'd4255);
    step();
    pcm_rden = 1'b0;
    drain();

    // Swap with reads in flight
    fill(32'd5000, 256);
    fill(32'd6000, 256);
    issue_rd(8'd255, 32'd5255);
    step();
    issue_rd(8'd0, 32'd6000);
    step();
    pcm_rden = 1'b0;
    drain();
    chk("ifs_rdy", 32'(pcm_data_rdy), 32'd1);

    // Reset with reads in flight and a partial fill
    issue_rd(8'd255, 32'd6255);
    step();
    pcm_rden = 1'b0;
    drain();
    fill(32'd7000, 256);
    fill(32'd7500, 100);
    pcm_rden = 1'b1;
    pcm_addr = 8'd5;
    step();
    pcm_addr = 8'd6;
    rst      = 1'b1;
    step();
    pcm_rden = 1'b0;
    rst      = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("rst2_valid", 32'(pcm_rd_valid), 32'd0);
      step();
    end
    chk("rst2_rdy", 32'(pcm_data_rdy), 32'd0);
    chk("rst2_rdata", pcm_rdata, 32'd0);
    chk("rst2_ovf", 32'(ovf_cnt), 32'd0);
    issue_rd(8'd0, 32'd7500);
    step();
    issue_rd(8'd150, 32'd6150);
    step();
    pcm_rden = 1'b0;
    drain();
    fill(32'd8000, 256);
    chk("rst2_fill_rdy", 32'(pcm_data_rdy), 32'd1);
    issue_rd(8'd0, 32'd8000);
    step();
    issue_rd(8'd99, 32'd8099);
    step();
    issue_rd(8'd200, 32'd8200);
    step();
    pcm_rden = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
